predicate_access_scheduler: RTL and testbench



---
 rtl/predicate_access_scheduler_if.sv | 42 ++++
 rtl/predicate_access_scheduler.sv | 81 ++++++++
 tb/tb_predicate_access_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/predicate_access_scheduler_if.sv
// predicate_access_scheduler_if: client handshakes and predicate register block bus of the scheduler
interface predicate_access_scheduler_if #(
  parameter int NUM_LANES = 16,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WARPS = 16
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int WARP_W = $clog2(NUM_WARPS);
  logic                 wb_valid, wb_ready;
  logic [WARP_W-1:0]    wb_warp;
  logic [ADDR_W-1:0]    wb_addr;
  logic [NUM_LANES-1:0] wb_mask, wb_data;
  logic                 rd_valid, rd_ready;
  logic [WARP_W-1:0]    rd_warp;
  logic [ADDR_W-1:0]    rd_addr0, rd_addr1;
  logic [NUM_LANES-1:0] rd_mask0, rd_mask1;
  logic                 rd_rsp_valid;
  logic [NUM_LANES-1:0] rd_rsp_data0, rd_rsp_data1;
  logic                 clr_valid, clr_ready, clr_done;
  logic [WARP_W-1:0]    clr_warp_in;
  logic [WARP_W-1:0]    pr_warp_selector;
  logic [NUM_LANES-1:0] pr_write_en, pr_wdata;
  logic [ADDR_W-1:0]    pr_waddr, pr_raddr_0, pr_raddr_1;
  logic [NUM_LANES-1:0] pr_read_en_0, pr_read_en_1;
  logic [NUM_LANES-1:0] pr_rdata_0, pr_rdata_1;
  modport slave (
    input  wb_valid, wb_warp, wb_addr, wb_mask, wb_data,
    input  rd_valid, rd_warp, rd_addr0, rd_addr1, rd_mask0, rd_mask1,
    input  clr_valid, clr_warp_in, pr_rdata_0, pr_rdata_1,
    output wb_ready, rd_ready, rd_rsp_valid, rd_rsp_data0, rd_rsp_data1,
    output clr_ready, clr_done, pr_warp_selector, pr_write_en, pr_wdata,
    output pr_waddr, pr_raddr_0, pr_raddr_1, pr_read_en_0, pr_read_en_1
  );
  modport master (
    output wb_valid, wb_warp, wb_addr, wb_mask, wb_data,
    output rd_valid, rd_warp, rd_addr0, rd_addr1, rd_mask0, rd_mask1,
    output clr_valid, clr_warp_in, pr_rdata_0, pr_rdata_1,
    input  wb_ready, rd_ready, rd_rsp_valid, rd_rsp_data0, rd_rsp_data1,
    input  clr_ready, clr_done, pr_warp_selector, pr_write_en, pr_wdata,
    input  pr_waddr, pr_raddr_0, pr_raddr_1, pr_read_en_0, pr_read_en_1
  );
endinterface

// File: rtl/predicate_access_scheduler.sv
// predicate_access_scheduler: arbitrates writeback, issue reads and warp clears onto one predicate block
module predicate_access_scheduler #(
  parameter int NUM_LANES = 16,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WARPS = 16
) (
  input logic clk,
  input logic rst_n,
  predicate_access_scheduler_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;
  logic [WARP_W-1:0] clr_warp, w_warp;
  logic [ADDR_W-1:0] clr_addr;
  logic rr, rd_issued;
  logic wb_elig, rd_elig, w_cand, conflict, grant_w, grant_rd, clr_grant;
  // rr: 0 favours the read side, 1 the write side, on a warp conflict
  always_comb begin
    wb_elig   = bus.wb_valid && !(state == SWEEP && bus.wb_warp == clr_warp);
    rd_elig   = bus.rd_valid && !(state == SWEEP && bus.rd_warp == clr_warp);
    w_cand    = wb_elig || state == SWEEP;
    w_warp    = wb_elig ? bus.wb_warp : clr_warp;
    conflict  = rd_elig && w_cand && bus.rd_warp != w_warp;
    grant_rd  = rd_elig && (!conflict || !rr);
    grant_w   = w_cand && (!conflict || rr);
    clr_grant = grant_w && !wb_elig;
    state_nx  = state == IDLE ? (bus.clr_valid ? SWEEP : IDLE)
                              : (clr_grant && clr_addr == LAST ? IDLE : SWEEP);
  end
  assign bus.wb_ready  = grant_w && wb_elig;
  assign bus.rd_ready  = grant_rd;
  assign bus.clr_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clr_warp             <= '0;
      clr_addr             <= '0;
      rr                   <= 1'b0;
      rd_issued            <= 1'b0;
      bus.pr_warp_selector <= '0;
      bus.pr_write_en      <= '0;
      bus.pr_wdata         <= '0;
      bus.pr_waddr         <= '0;
      bus.pr_raddr_0       <= '0;
      bus.pr_raddr_1       <= '0;
      bus.pr_read_en_0     <= '0;
      bus.pr_read_en_1     <= '0;
      bus.rd_rsp_valid     <= 1'b0;
      bus.rd_rsp_data0     <= '0;
      bus.rd_rsp_data1     <= '0;
      bus.clr_done         <= 1'b0;
    end else begin
      if (state == IDLE && bus.clr_valid) begin
        clr_warp <= bus.clr_warp_in;
        clr_addr <= '0;
      end else if (clr_grant) clr_addr <= clr_addr + 1'b1;
      if (conflict) rr <= ~rr;
      bus.pr_write_en <= grant_w ? (wb_elig ? bus.wb_mask : {NUM_LANES{1'b1}}) : '0;
      if (grant_w) begin
        bus.pr_wdata <= wb_elig ? bus.wb_data : '0;
        bus.pr_waddr <= wb_elig ? bus.wb_addr : clr_addr;
      end
      bus.pr_read_en_0 <= grant_rd ? bus.rd_mask0 : '0;
      bus.pr_read_en_1 <= grant_rd ? bus.rd_mask1 : '0;
      if (grant_rd) begin
        bus.pr_raddr_0 <= bus.rd_addr0;
        bus.pr_raddr_1 <= bus.rd_addr1;
      end
      if (grant_w || grant_rd) bus.pr_warp_selector <= grant_w ? w_warp : bus.rd_warp;
      rd_issued        <= grant_rd;
      bus.rd_rsp_valid <= rd_issued;
      bus.rd_rsp_data0 <= bus.pr_rdata_0 & bus.pr_read_en_0;
      bus.rd_rsp_data1 <= bus.pr_rdata_1 & bus.pr_read_en_1;
      bus.clr_done     <= clr_grant && clr_addr == LAST;
    end
endmodule

// File: tb/tb_predicate_access_scheduler.sv
// tb_predicate_access_scheduler: directed checks of arbitration, timing and clear sweeps
module tb_predicate_access_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  predicate_access_scheduler_if bus();
  predicate_access_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] mem [16][32] = '{default: '0};
  always @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (bus.pr_write_en[i]) mem[bus.pr_warp_selector][bus.pr_waddr][i] <= bus.pr_wdata[i];
  assign bus.pr_rdata_0 = mem[bus.pr_warp_selector][bus.pr_raddr_0];
  assign bus.pr_rdata_1 = mem[bus.pr_warp_selector][bus.pr_raddr_1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_write(input int w, input int a, input logic [15:0] m, input logic [15:0] d);
    bus.wb_valid = 1; bus.wb_warp = 4'(w); bus.wb_addr = 5'(a); bus.wb_mask = m; bus.wb_data = d;
    #1 chk("wb_ready", bus.wb_ready, 1);
    @(posedge clk); #1 bus.wb_valid = 0;
  endtask
  task automatic do_read(input int w, input int a0, input int a1, input logic [15:0] m0,
                         input logic [15:0] m1, input logic [15:0] e0, input logic [15:0] e1);
    bus.rd_valid = 1; bus.rd_warp = 4'(w); bus.rd_addr0 = 5'(a0); bus.rd_addr1 = 5'(a1);
    bus.rd_mask0 = m0; bus.rd_mask1 = m1;
    #1 chk("rd_ready", bus.rd_ready, 1);
    @(posedge clk); #1 bus.rd_valid = 0;
    chk("rsp_not_early", bus.rd_rsp_valid, 0);
    @(posedge clk); #1;
    chk("rsp_valid", bus.rd_rsp_valid, 1);
    chk("rsp_data0", bus.rd_rsp_data0, e0);
    chk("rsp_data1", bus.rd_rsp_data1, e1);
  endtask
  task automatic fill(input int w, input logic [15:0] d);
    for (int a = 0; a < 32; a++) do_write(w, a, 16'hFFFF, d);
    @(posedge clk); #1;
  endtask
  task automatic start_clear(input int w);
    bus.clr_valid = 1; bus.clr_warp_in = 4'(w);
    #1 chk("clr_ready_idle", bus.clr_ready, 1);
    @(posedge clk); #1 bus.clr_valid = 0;
  endtask
  int n, rds;
  bit seen;
  initial begin
    bus.wb_valid = 0; bus.wb_warp = 0; bus.wb_addr = 0; bus.wb_mask = 0; bus.wb_data = 0;
    bus.rd_valid = 0; bus.rd_warp = 0; bus.rd_addr0 = 0; bus.rd_addr1 = 0;
    bus.rd_mask0 = 0; bus.rd_mask1 = 0; bus.clr_valid = 0; bus.clr_warp_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write_en", bus.pr_write_en, 0);
    chk("rst_read_en0", bus.pr_read_en_0, 0);
    chk("rst_selector", bus.pr_warp_selector, 0);
    chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
    chk("rst_rsp_data0", bus.rd_rsp_data0, 0);
    chk("rst_clr_done", bus.clr_done, 0);
    chk("rst_clr_ready", bus.clr_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;
    do_write(3, 5, 16'hFFFF, 16'hA5A5);
    chk("wr_pr_write_en", bus.pr_write_en, 16'hFFFF);
    chk("wr_pr_waddr", bus.pr_waddr, 5);
    chk("wr_pr_wdata", bus.pr_wdata, 16'hA5A5);
    chk("wr_pr_selector", bus.pr_warp_selector, 3);
    do_read(3, 5, 5, 16'hFFFF, 16'hFFFF, 16'hA5A5, 16'hA5A5);
    @(posedge clk); #1 chk("rsp_single", bus.rd_rsp_valid, 0);
    bus.wb_valid = 1; bus.wb_warp = 2; bus.wb_addr = 9; bus.wb_mask = 16'hFFFF; bus.wb_data = 16'h1234;
    bus.rd_valid = 1; bus.rd_warp = 2; bus.rd_addr0 = 9; bus.rd_addr1 = 9;
    bus.rd_mask0 = 16'hFFFF; bus.rd_mask1 = 16'hFFFF;
    #1;
    chk("same_wb_ready", bus.wb_ready, 1);
    chk("same_rd_ready", bus.rd_ready, 1);
    @(posedge clk); #1 bus.wb_valid = 0; bus.rd_valid = 0;
    chk("same_write_en", bus.pr_write_en, 16'hFFFF);
    chk("same_read_en", bus.pr_read_en_0, 16'hFFFF);
    chk("same_selector", bus.pr_warp_selector, 2);
    @(posedge clk); #1;
    chk("same_rsp_valid", bus.rd_rsp_valid, 1);
    chk("same_old_data", bus.rd_rsp_data0, 16'h0000);
    do_read(2, 9, 9, 16'hFFFF, 16'h00FF, 16'h1234, 16'h0034);
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    bus.wb_valid = 1; bus.wb_warp = 1; bus.wb_addr = 0; bus.wb_mask = 16'hFFFF; bus.wb_data = 16'h00F0;
    bus.rd_valid = 1; bus.rd_warp = 2; bus.rd_addr0 = 0; bus.rd_addr1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rd_ready", bus.rd_ready, (i % 2) == 0);
      chk("rr_wb_ready", bus.wb_ready, (i % 2) == 1);
      @(posedge clk); #1;
    end
    bus.wb_valid = 0; bus.rd_valid = 0;
    @(posedge clk); #1;
    fill(7, 16'hFFFF);
    start_clear(7);
    chk("sweep_clr_ready", bus.clr_ready, 0);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk("sweep_write_en", bus.pr_write_en, 16'hFFFF);
      chk("sweep_waddr", bus.pr_waddr, i);
      chk("sweep_wdata", bus.pr_wdata, 0);
      chk("sweep_selector", bus.pr_warp_selector, 7);
      chk("sweep_clr_done", bus.clr_done, i == 31);
      chk("sweep_clr_ready", bus.clr_ready, i == 31);
    end
    @(posedge clk); #1;
    chk("sweep_done_once", bus.clr_done, 0);
    chk("sweep_idle_write", bus.pr_write_en, 0);
    do_read(7, 0, 31, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    start_clear(7);
    bus.wb_valid = 1; bus.wb_warp = 7; bus.wb_addr = 3; bus.wb_mask = 16'hFFFF; bus.wb_data = 16'h5555;
    bus.rd_warp = 4; bus.rd_addr0 = 0; bus.rd_addr1 = 1; bus.rd_mask0 = 16'hFFFF; bus.rd_mask1 = 16'hFFFF;
    n = 0; rds = 0; seen = 0;
    while (!seen && n < 100) begin
      bus.rd_valid = rds < 4;
      #1;
      if (bus.clr_done) seen = 1;
      else begin
        chk("stall_wb_ready", bus.wb_ready, 0);
        if (bus.rd_valid && bus.rd_ready) rds++;
        @(posedge clk); #1;
        n++;
      end
    end
    chk("stall_done_seen", seen, 1);
    chk("stall_reads", rds, 4);
    chk("stall_length", n, 36);
    chk("stall_wb_release", bus.wb_ready, 1);
    @(posedge clk); #1 bus.wb_valid = 0;
    do_read(7, 3, 0, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0000);
    fill(7, 16'hFFFF);
    start_clear(7);
    repeat (10) @(posedge clk);
    #1 chk("mid_waddr", bus.pr_waddr, 9);
    rst_n = 0;
    #1;
    chk("mid_rst_write_en", bus.pr_write_en, 0);
    chk("mid_rst_waddr", bus.pr_waddr, 0);
    chk("mid_rst_selector", bus.pr_warp_selector, 0);
    chk("mid_rst_rsp_valid", bus.rd_rsp_valid, 0);
    chk("mid_rst_clr_ready", bus.clr_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      chk("mid_no_done", bus.clr_done, 0);
      chk("mid_no_write", bus.pr_write_en, 0);
      @(posedge clk); #1;
    end
    do_read(7, 0, 10, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF);
    do_read(7, 31, 8, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
